// File: rtl/axi_esdi_drive_emulator.sv
// axi_esdi_drive_emulator
// Emulates the rotational timing of a hard-sectored ESDI drive. Programmable
// revolution and sector lengths produce active-low index and sector pulses.
// The controller's read gate and address-mark-enable inputs are synchronised
// and monitored. An address-mark-found pulse is returned after a programmable
// delay.
//
// Ports:
//   csr_aclk, csr_aresetn        clock, asynchronous active-low reset
//   csr_aw*/w*/b*/ar*/r*         AXI4-Lite slave (5-bit address, 32-bit data)
//   esdi_read_gate               async input, active-high
//   esdi_address_mark_enable     async input, active-high
//   esdi_index                   active-low index pulse (registered)
//   esdi_sector                  active-low sector pulse (registered)
//   esdi_address_mark_found      active-low AMF pulse (registered)
//
// Register map (byte addresses):
//   0x00 control {amf_enable, soft_reset, enable}
//   0x04 status  {rg_count, sector_num} (RO)
//   0x08 rev_length   0x0C sector_length   0x10 pulse_width[15:0]
//   0x14 amf_delay    0x18 last_rg_phase (RO)   0x1C last_rg_sector (RO)
module axi_esdi_drive_emulator #(
  parameter logic [31:0] DEFAULT_REV_LENGTH    = 32'd100000,
  parameter logic [31:0] DEFAULT_SECTOR_LENGTH = 32'd3000,
  parameter logic [15:0] DEFAULT_PULSE_WIDTH   = 16'd8
) (
  input  logic        csr_aclk,
  input  logic        csr_aresetn,
  input  logic [4:0]  csr_awaddr,
  input  logic [2:0]  csr_awprot,
  input  logic        csr_awvalid,
  output logic        csr_awready,
  input  logic [31:0] csr_wdata,
  input  logic [3:0]  csr_wstrb,
  input  logic        csr_wvalid,
  output logic        csr_wready,
  output logic [1:0]  csr_bresp,
  output logic        csr_bvalid,
  input  logic        csr_bready,
  input  logic [4:0]  csr_araddr,
  input  logic [2:0]  csr_arprot,
  input  logic        csr_arvalid,
  output logic        csr_arready,
  output logic [31:0] csr_rdata,
  output logic [1:0]  csr_rresp,
  output logic        csr_rvalid,
  input  logic        csr_rready,
  input  logic        esdi_read_gate,
  input  logic        esdi_address_mark_enable,
  output logic        esdi_index,
  output logic        esdi_sector,
  output logic        esdi_address_mark_found
);

  // Next {active-low output, remaining count} of a retriggerable pulse.
  // The start edge drives the output low and leaves width-1 further low cycles.
  function automatic logic [16:0] f_pulse_next(input logic        i_start,
                                               input logic        i_cancel,
                                               input logic [15:0] i_cnt,
                                               input logic [15:0] i_width);
    logic [16:0] v_next;
    if (i_cancel || (i_width == 16'd0)) begin
      v_next = {1'b1, 16'd0};
    end else if (i_start) begin
      v_next = {1'b0, i_width - 16'd1};
    end else if (i_cnt != 16'd0) begin
      v_next = {1'b0, i_cnt - 16'd1};
    end else begin
      v_next = {1'b1, 16'd0};
    end
    return v_next;
  endfunction

  // CSR state
  logic        r_aw_held, r_w_held, r_bvalid, r_rvalid;
  logic [2:0]  r_awaddr;
  logic [31:0] r_wdata, r_rdata;
  logic [2:0]  r_ctrl;
  logic [31:0] r_rev_length, r_sector_length, r_amf_delay;
  logic [15:0] r_pulse_width;
  // Timing state
  logic        r_running;
  logic [31:0] r_rev_count, r_sector_phase;
  logic [15:0] r_sector_num;
  logic        r_index, r_sector, r_amf;
  logic [15:0] r_idx_cnt, r_sec_cnt, r_amf_cnt;
  // Input monitoring state
  logic        r_rg_s1, r_rg_s2, r_rg_d, r_ame_s1, r_ame_s2, r_both_d;
  logic [15:0] r_rg_count, r_last_rg_sector;
  logic [31:0] r_last_rg_phase;
  logic        r_amf_pend;
  logic [31:0] r_amf_wait;

  logic        w_commit, w_arready, w_active;
  logic [31:0] w_rdata_mux;
  logic [32:0] w_rev_inc, w_phase_inc;
  logic        w_idx_start, w_sec_start, w_amf_start;
  logic [31:0] w_rev_next, w_phase_next;
  logic [15:0] w_num_next;
  logic        w_rg_rise, w_rg_fall, w_both, w_amf_trig;
  logic        w_amf_pend_next;
  logic [31:0] w_amf_wait_next;
  logic        w_unused_ok;

  assign csr_awready = ~r_aw_held;
  assign csr_wready  = ~r_w_held;
  assign csr_bresp   = 2'b00;
  assign csr_bvalid  = r_bvalid;
  assign w_arready   = ~r_rvalid | csr_rready;
  assign csr_arready = w_arready;
  assign csr_rdata   = r_rdata;
  assign csr_rresp   = 2'b00;
  assign csr_rvalid  = r_rvalid;
  assign esdi_index  = r_index;
  assign esdi_sector = r_sector;
  assign esdi_address_mark_found = r_amf;

  assign w_commit    = r_aw_held & r_w_held & (~r_bvalid | csr_bready);
  assign w_active    = r_ctrl[0] & ~r_ctrl[1];
  assign w_rev_inc   = {1'b0, r_rev_count} + 33'd1;
  assign w_phase_inc = {1'b0, r_sector_phase} + 33'd1;
  assign w_rg_rise   = r_rg_s2 & ~r_rg_d;
  assign w_rg_fall   = ~r_rg_s2 & r_rg_d;
  assign w_both      = r_rg_s2 & r_ame_s2;
  assign w_amf_trig  = r_ctrl[2] & w_both & ~r_both_d;
  assign w_unused_ok = ^{csr_awprot, csr_arprot, csr_wstrb,
                         csr_awaddr[1:0], csr_araddr[1:0]};

  // Write channel: hold address/data independently, commit when both present
  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      r_aw_held       <= 1'b0;
      r_w_held        <= 1'b0;
      r_awaddr        <= 3'd0;
      r_wdata         <= 32'd0;
      r_bvalid        <= 1'b0;
      r_ctrl          <= 3'd0;
      r_rev_length    <= DEFAULT_REV_LENGTH;
      r_sector_length <= DEFAULT_SECTOR_LENGTH;
      r_pulse_width   <= DEFAULT_PULSE_WIDTH;
      r_amf_delay     <= 32'd0;
    end else begin
      if (csr_awvalid && !r_aw_held) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= csr_awaddr[4:2];
      end
      if (csr_wvalid && !r_w_held) begin
        r_w_held <= 1'b1;
        r_wdata  <= csr_wdata;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        case (r_awaddr)
          3'd0:    r_ctrl          <= r_wdata[2:0];
          3'd2:    r_rev_length    <= r_wdata;
          3'd3:    r_sector_length <= r_wdata;
          3'd4:    r_pulse_width   <= r_wdata[15:0];
          3'd5:    r_amf_delay     <= r_wdata;
          default: ;
        endcase
      end else if (csr_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read data mux (values before any same-edge write)
  always_comb begin
    w_rdata_mux = 32'd0;
    case (csr_araddr[4:2])
      3'd0:    w_rdata_mux = {29'd0, r_ctrl};
      3'd1:    w_rdata_mux = {r_rg_count, r_sector_num};
      3'd2:    w_rdata_mux = r_rev_length;
      3'd3:    w_rdata_mux = r_sector_length;
      3'd4:    w_rdata_mux = {16'd0, r_pulse_width};
      3'd5:    w_rdata_mux = r_amf_delay;
      3'd6:    w_rdata_mux = r_last_rg_phase;
      3'd7:    w_rdata_mux = {16'd0, r_last_rg_sector};
      default: w_rdata_mux = 32'd0;
    endcase
  end

  // Read channel: register data on the accepted edge
  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
    end else if (csr_arvalid && w_arready) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rdata_mux;
    end else if (csr_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // Rotation counters: revolution wrap wins over sector wrap
  always_comb begin
    w_idx_start  = 1'b0;
    w_sec_start  = 1'b0;
    w_rev_next   = r_rev_count;
    w_phase_next = r_sector_phase;
    w_num_next   = r_sector_num;
    if (!w_active) begin
      w_rev_next   = 32'd0;
      w_phase_next = 32'd0;
      w_num_next   = 16'd0;
    end else if (!r_running || (w_rev_inc >= {1'b0, r_rev_length})) begin
      // first enabled edge behaves like a revolution wrap
      w_idx_start  = 1'b1;
      w_rev_next   = 32'd0;
      w_phase_next = 32'd0;
      w_num_next   = 16'd0;
    end else if (w_phase_inc >= {1'b0, r_sector_length}) begin
      w_sec_start  = 1'b1;
      w_rev_next   = w_rev_inc[31:0];
      w_phase_next = 32'd0;
      w_num_next   = r_sector_num + 16'd1;
    end else begin
      w_rev_next   = w_rev_inc[31:0];
      w_phase_next = w_phase_inc[31:0];
    end
  end

  // AMF countdown: trigger arms, rg falling cancels
  always_comb begin
    w_amf_start     = 1'b0;
    w_amf_pend_next = r_amf_pend;
    w_amf_wait_next = r_amf_wait;
    if (!w_active || w_rg_fall) begin
      w_amf_pend_next = 1'b0;
      w_amf_wait_next = 32'd0;
    end else if (w_amf_trig) begin
      if (r_amf_delay == 32'd0) begin
        w_amf_start     = 1'b1;
        w_amf_pend_next = 1'b0;
        w_amf_wait_next = 32'd0;
      end else begin
        w_amf_pend_next = 1'b1;
        w_amf_wait_next = r_amf_delay;
      end
    end else if (r_amf_pend) begin
      if (r_amf_wait <= 32'd1) begin
        w_amf_start     = 1'b1;
        w_amf_pend_next = 1'b0;
        w_amf_wait_next = 32'd0;
      end else begin
        w_amf_wait_next = r_amf_wait - 32'd1;
      end
    end else begin
      w_amf_wait_next = 32'd0;
    end
  end

  // Counters, AMF engine and the three registered pulse outputs
  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      r_running      <= 1'b0;
      r_rev_count    <= 32'd0;
      r_sector_phase <= 32'd0;
      r_sector_num   <= 16'd0;
      r_amf_pend     <= 1'b0;
      r_amf_wait     <= 32'd0;
      r_index        <= 1'b1;
      r_sector       <= 1'b1;
      r_amf          <= 1'b1;
      r_idx_cnt      <= 16'd0;
      r_sec_cnt      <= 16'd0;
      r_amf_cnt      <= 16'd0;
    end else begin
      r_running      <= w_active;
      r_rev_count    <= w_rev_next;
      r_sector_phase <= w_phase_next;
      r_sector_num   <= w_num_next;
      r_amf_pend     <= w_amf_pend_next;
      r_amf_wait     <= w_amf_wait_next;
      {r_index,  r_idx_cnt} <= f_pulse_next(w_idx_start, ~w_active, r_idx_cnt, r_pulse_width);
      {r_sector, r_sec_cnt} <= f_pulse_next(w_sec_start, ~w_active, r_sec_cnt, r_pulse_width);
      {r_amf,    r_amf_cnt} <= f_pulse_next(w_amf_start, ~w_active | w_rg_fall,
                                            r_amf_cnt, r_pulse_width);
    end
  end

  // Two-flop synchronisers plus edge-detect history
  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      r_rg_s1  <= 1'b0;
      r_rg_s2  <= 1'b0;
      r_rg_d   <= 1'b0;
      r_ame_s1 <= 1'b0;
      r_ame_s2 <= 1'b0;
      r_both_d <= 1'b0;
    end else begin
      r_rg_s1  <= esdi_read_gate;
      r_rg_s2  <= r_rg_s1;
      r_rg_d   <= r_rg_s2;
      r_ame_s1 <= esdi_address_mark_enable;
      r_ame_s2 <= r_ame_s1;
      r_both_d <= w_both;
    end
  end

  // Read-gate statistics; snapshot the position at each rising edge
  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      r_rg_count       <= 16'd0;
      r_last_rg_phase  <= 32'd0;
      r_last_rg_sector <= 16'd0;
    end else if (r_ctrl[1]) begin
      r_rg_count       <= 16'd0;
      r_last_rg_phase  <= 32'd0;
      r_last_rg_sector <= 16'd0;
    end else if (w_rg_rise) begin
      if (r_rg_count != 16'hFFFF) begin
        r_rg_count <= r_rg_count + 16'd1;
      end
      r_last_rg_phase  <= r_sector_phase;
      r_last_rg_sector <= r_sector_num;
    end
  end

endmodule

// File: tb/tb_axi_esdi_drive_emulator.sv
// Self-checking bench for axi_esdi_drive_emulator. CSR read expectations go
// through a scoreboard queue; pulse timing is checked cycle by cycle against
// expectations computed from the programmed revolution/sector geometry.
module tb_axi_esdi_drive_emulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  awaddr = 5'd0, araddr = 5'd0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic [31:0] wdata = 32'd0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        rg = 1'b0, ame = 1'b0;
  logic        index_n, sector_n, amf_n;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int t_commit = 0;

  typedef struct packed { logic [31:0] exp; logic [31:0] mask; } rd_t;
  rd_t rd_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_esdi_drive_emulator dut (
    .csr_aclk(clk), .csr_aresetn(rst_n),
    .csr_awaddr(awaddr), .csr_awprot(3'd0), .csr_awvalid(awvalid), .csr_awready(awready),
    .csr_wdata(wdata), .csr_wstrb(4'hF), .csr_wvalid(wvalid), .csr_wready(wready),
    .csr_bresp(bresp), .csr_bvalid(bvalid), .csr_bready(bready),
    .csr_araddr(araddr), .csr_arprot(3'd0), .csr_arvalid(arvalid), .csr_arready(arready),
    .csr_rdata(rdata), .csr_rresp(rresp), .csr_rvalid(rvalid), .csr_rready(rready),
    .esdi_read_gate(rg), .esdi_address_mark_enable(ame),
    .esdi_index(index_n), .esdi_sector(sector_n), .esdi_address_mark_found(amf_n)
  );

  // Write; t_commit gets the cycle of the commit edge (bvalid rises there).
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d);
    bit a_hs, d_hs, done;
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    done = 1'b0; n = 0;
    while (!done && n < 20) begin
      a_hs = awvalid && awready;
      d_hs = wvalid && wready;
      @(negedge clk);
      if (a_hs) awvalid = 1'b0;
      if (d_hs) wvalid = 1'b0;
      if (bvalid) begin done = 1'b1; t_commit = cyc; end
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h: bvalid=0, required 1", a);
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] exp,
                          input logic [31:0] mask, input string name);
    rd_t e;
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    rd_q.push_back({exp, mask});
    @(negedge clk);
    arvalid = 1'b0; n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    e = rd_q.pop_front();
    checks++;
    if (!rvalid) begin
      errors++;
      $display("FAIL %s: rvalid=0 (timeout), required 1", name);
    end else if (((rdata & e.mask) !== (e.exp & e.mask)) || (rresp !== 2'b00)) begin
      errors++;
      $display("FAIL %s: got %h resp %0d, required %h resp 0", name,
               rdata & e.mask, rresp, e.exp & e.mask);
    end
  endtask

  task automatic wait_until(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 5000) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({index_n, sector_n, amf_n, bvalid, rvalid} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 11100", {index_n, sector_n, amf_n, bvalid, rvalid});
    end
    rst_n = 1'b1;
    axi_read(5'h00, 32'd0, 32'hFFFFFFFF, "reset_control");
    axi_read(5'h08, 32'd100000, 32'hFFFFFFFF, "reset_rev_length");
    axi_read(5'h0C, 32'd3000, 32'hFFFFFFFF, "reset_sector_length");
    axi_read(5'h10, 32'd8, 32'hFFFFFFFF, "reset_pulse_width");
    axi_read(5'h04, 32'd0, 32'hFFFFFFFF, "reset_status");
  endtask

  task automatic test_back_to_back();
    rd_t e;
    @(negedge clk);
    awaddr = 5'h14; wdata = 32'd77; awvalid = 1'b1; wvalid = 1'b1;
    checks++;
    if (!(awready && wready)) begin
      errors++; $display("FAIL b2b_ready: got %b%b, required 11", awready, wready);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 5'h14; arvalid = 1'b1;
    rd_q.push_back({32'd0, 32'hFFFFFFFF});
    @(negedge clk);
    arvalid = 1'b0;
    e = rd_q.pop_front();
    checks++;
    if (!rvalid || (rdata !== e.exp)) begin
      errors++; $display("FAIL b2b_read_old: got rvalid=%b data=%h, required 1 %h", rvalid, rdata, e.exp);
    end
    checks++;
    if (bvalid !== 1'b1) begin
      errors++; $display("FAIL b2b_bvalid: got %b, required 1", bvalid);
    end
    axi_read(5'h14, 32'd77, 32'hFFFFFFFF, "b2b_read_new");
  endtask

  task automatic test_rotation();
    int sl, c0, rp;
    logic exp_i, exp_s;
    rd_t e;
    for (int p = 0; p < 2; p++) begin
      sl = (p == 0) ? 250 : 300;
      axi_write(5'h00, 32'd0);
      axi_write(5'h08, 32'd1000);
      axi_write(5'h0C, sl);
      axi_write(5'h10, 32'd4);
      axi_write(5'h00, 32'd1);
      c0 = t_commit + 1;
      for (int k = 0; k <= 1010; k++) begin
        @(negedge clk);
        rp = k % 1000;
        exp_i = !(rp < 4);
        exp_s = !((rp >= sl) && ((rp % sl) < 4));
        checks++;
        if ({index_n, sector_n} !== {exp_i, exp_s}) begin
          errors++;
          $display("FAIL rot_sl%0d_cyc%0d: got idx/sec %b%b, required %b%b", sl, cyc - c0,
                   index_n, sector_n, exp_i, exp_s);
        end
        if (k == 900 || k == 1005) begin
          araddr = 5'h04; arvalid = 1'b1;
          rd_q.push_back({(k == 900) ? 32'd3 : 32'd0, 32'h0000FFFF});
        end
        if (k == 901 || k == 1006) begin
          arvalid = 1'b0;
          e = rd_q.pop_front();
          checks++;
          if (!rvalid || ((rdata & e.mask) !== e.exp)) begin
            errors++;
            $display("FAIL rot_sector_num_k%0d: got %b %h, required 1 %h", k, rvalid, rdata & e.mask, e.exp);
          end
        end
      end
    end
  endtask

  task automatic test_read_gate();
    int c0;
    axi_write(5'h00, 32'd0);
    axi_write(5'h08, 32'd1000);
    axi_write(5'h0C, 32'd300);
    axi_write(5'h00, 32'd2);
    axi_write(5'h00, 32'd1);
    c0 = t_commit + 1;
    wait_until(c0 + 700);
    rg = 1'b1;
    repeat (6) @(negedge clk);
    rg = 1'b0;
    repeat (4) @(negedge clk);
    axi_read(5'h18, 32'd102, 32'hFFFFFFFF, "rg_last_phase");
    axi_read(5'h1C, 32'd2, 32'hFFFFFFFF, "rg_last_sector");
    axi_read(5'h04, 32'h00010000, 32'hFFFF0000, "rg_count_1");
    rg = 1'b1;
    repeat (5) @(negedge clk);
    rg = 1'b0;
    repeat (4) @(negedge clk);
    axi_read(5'h04, 32'h00020000, 32'hFFFF0000, "rg_count_2");
  endtask

  task automatic test_amf();
    int t, lo, hi;
    logic exp_a;
    axi_write(5'h00, 32'd0);
    axi_write(5'h08, 32'd100000);
    axi_write(5'h10, 32'd4);
    for (int c = 0; c < 3; c++) begin
      axi_write(5'h14, (c == 2) ? 32'd0 : 32'd10);
      axi_write(5'h00, 32'd5);
      repeat (5) @(negedge clk);
      rg = 1'b1; ame = 1'b1;
      t = cyc + 1;
      lo = (c == 2) ? t + 2 : t + 12;
      hi = lo + 3;
      for (int k = 0; k < 25; k++) begin
        @(negedge clk);
        if (c == 1 && cyc == t + 4) rg = 1'b0;
        exp_a = (c == 1) ? 1'b1 : !((cyc >= lo) && (cyc <= hi));
        checks++;
        if (amf_n !== exp_a) begin
          errors++;
          $display("FAIL amf_case%0d_t+%0d: got %b, required %b", c, cyc - t, amf_n, exp_a);
        end
      end
      rg = 1'b0; ame = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_rev_change();
    int c0, rp, tc;
    logic exp_i, exp_s;
    axi_write(5'h00, 32'd0);
    axi_write(5'h08, 32'd1000);
    axi_write(5'h0C, 32'd300);
    axi_write(5'h10, 32'd4);
    axi_write(5'h00, 32'd1);
    c0 = t_commit + 1;
    wait_until(c0 + 795);
    axi_write(5'h08, 32'd500);
    tc = t_commit;
    for (int k = 1; k <= 1005; k++) begin
      @(negedge clk);
      rp = (cyc - tc - 1) % 500;
      exp_i = !(rp < 4);
      exp_s = !((rp >= 300) && (rp < 304));
      checks++;
      if ({index_n, sector_n} !== {exp_i, exp_s}) begin
        errors++;
        $display("FAIL revchg_commit+%0d: got idx/sec %b%b, required %b%b", cyc - tc,
                 index_n, sector_n, exp_i, exp_s);
      end
    end
  endtask

  task automatic test_soft_disable();
    int c0;
    axi_write(5'h00, 32'd0);
    axi_write(5'h08, 32'd1000);
    axi_write(5'h0C, 32'd250);
    axi_write(5'h10, 32'd20);
    axi_write(5'h00, 32'd1);
    c0 = t_commit + 1;
    wait_until(c0 + 255);
    axi_write(5'h00, 32'd3);
    checks++;
    if (sector_n !== 1'b0) begin
      errors++; $display("FAIL soft_pre_sector: got %b, required 0", sector_n);
    end
    @(negedge clk);
    checks++;
    if ({index_n, sector_n, amf_n} !== 3'b111) begin
      errors++; $display("FAIL soft_outputs: got %b, required 111", {index_n, sector_n, amf_n});
    end
    axi_read(5'h04, 32'd0, 32'hFFFFFFFF, "soft_status");
    axi_read(5'h18, 32'd0, 32'hFFFFFFFF, "soft_last_phase");
    axi_write(5'h00, 32'd1);
    @(negedge clk);
    checks++;
    if (index_n !== 1'b0) begin
      errors++; $display("FAIL soft_restart_index: got %b, required 0", index_n);
    end
    axi_write(5'h00, 32'd0);
    checks++;
    if (index_n !== 1'b0) begin
      errors++; $display("FAIL disable_commit_index: got %b, required 0", index_n);
    end
    @(negedge clk);
    checks++;
    if (index_n !== 1'b1) begin
      errors++; $display("FAIL disable_next_index: got %b, required 1", index_n);
    end
    axi_write(5'h00, 32'd1);
    repeat (3) @(negedge clk);
    checks++;
    if (index_n !== 1'b0) begin
      errors++; $display("FAIL arst_pre_index: got %b, required 0", index_n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({index_n, sector_n, amf_n} !== 3'b111) begin
      errors++; $display("FAIL arst_outputs: got %b, required 111", {index_n, sector_n, amf_n});
    end
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(5'h08, 32'd100000, 32'hFFFFFFFF, "arst_rev_length");
    axi_read(5'h0C, 32'd3000, 32'hFFFFFFFF, "arst_sector_length");
    axi_read(5'h10, 32'd8, 32'hFFFFFFFF, "arst_pulse_width");
    axi_read(5'h00, 32'd0, 32'hFFFFFFFF, "arst_control");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_rotation();
    test_read_gate();
    test_amf();
    test_rev_change();
    test_soft_disable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
